// File: rtl/cpu_pkg.sv
// Constants and encodings shared by the CPU result path, this converter and the LCD driver.
package cpu_pkg;

  localparam int MAG_W           = 15;
  localparam int DIGITS          = 5;
  localparam int RESULT_SIGN_BIT = 15;

  // CPU state encodings seen by the display path
  localparam logic [2:0] CPU_OFF   = 3'b000;
  localparam logic [2:0] CPU_SHOW  = 3'b101;
  localparam logic [2:0] CPU_STORE = 3'b110;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_STORE   = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_OR      = 3'b101;
  localparam logic [2:0] OP_JMP     = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // 5..9 plus 3 stays within 4 bits, so no carry out is needed
  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/result_bcd.sv
// Sign-magnitude to BCD converter feeding the LCD driver; one double-dabble step per clock.
module result_bcd #(
  parameter int MAG_W  = 15,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MAG_W:0]        result,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  import cpu_pkg::*;

  localparam int ITER  = MAG_W;
  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + MAG_W;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  bcd_state_e       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_sign_q, pend_sign_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [BCD_W-1:0]  bcd_fix;
  logic [SR_W-1:0]   sr_fix;
  logic [DIGITS-1:0] blank_calc;
  logic              seen_nz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (sr_q[MAG_W + 4*g +: 4]),
      .d_o (bcd_fix[4*g +: 4])
    );
  end

  assign sr_fix = {bcd_fix, sr_q[MAG_W-1:0]};

  // Leading digits stay blank until the first nonzero one; units is never blank
  always_comb begin
    seen_nz    = 1'b0;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz       = seen_nz | (sr_q[MAG_W + 4*i +: 4] != 4'd0);
      blank_calc[i] = ~seen_nz;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    pend_sign_d = pend_sign_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    blank_d     = blank_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          sr_d        = {{BCD_W{1'b0}}, result[MAG_W-1:0]};
          // negative zero is shown as +0
          pend_sign_d = result[MAG_W] & (|result[MAG_W-1:0]);
          cnt_d       = CNT_W'(ITER);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sr_d  = sr_fix << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          bcd_d   = sr_q[SR_W-1 -: BCD_W];
          sign_d  = pend_sign_q;
          blank_d = blank_calc;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      pend_sign_q <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      blank_q     <= BLANK_RST;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      pend_sign_q <= pend_sign_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      blank_q     <= blank_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sign  = sign_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_result_bcd.sv
// Bench for result_bcd: directed vectors and a sweep, checked by a done-triggered scoreboard.
module tb_result_bcd;

  localparam int EXP_W = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        sign;
  logic [19:0] bcd;
  logic [4:0]  blank;

  always #5 clk = ~clk;

  result_bcd dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .result (result),
    .busy   (busy),
    .done   (done),
    .sign   (sign),
    .bcd    (bcd),
    .blank  (blank)
  );

  // expected entry = {sign, blank[4:0], bcd[19:0]}
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_exp;
  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] r;
    logic [19:0] b;
    logic        s;
    logic [4:0]  blk;
  } vec_t;

  vec_t dir_tab [9] = '{
    '{16'h7FFF, 20'h32767, 1'b0, 5'b00000},
    '{16'h8453, 20'h01107, 1'b1, 5'b10000},
    '{16'h0000, 20'h00000, 1'b0, 5'b11110},
    '{16'h8000, 20'h00000, 1'b0, 5'b11110},
    '{16'h8001, 20'h00001, 1'b1, 5'b11110},
    '{16'h03E8, 20'h01000, 1'b0, 5'b10000},
    '{16'h2710, 20'h10000, 1'b0, 5'b00000},
    '{16'h270F, 20'h09999, 1'b0, 5'b10000},
    '{16'h8063, 20'h00099, 1'b1, 5'b11100}
  };

  function automatic logic [EXP_W-1:0] model(input logic [15:0] r);
    int          mag;
    int          p;
    logic [19:0] b;
    logic [4:0]  blk;
    mag = int'(r[14:0]);
    p   = 1;
    b   = '0;
    blk = '0;
    for (int k = 0; k < 5; k++) begin
      b[4*k +: 4] = 4'((mag / p) % 10);
      if (k > 0 && mag < p) blk[k] = 1'b1;
      p = p * 10;
    end
    return {(r[15] && mag != 0), blk, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got sign=%0b blank=%05b bcd=%05h, none expected at %0t",
                 sign, blank, bcd, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({sign, blank, bcd} !== mon_exp) begin
          bad++;
          $display("FAIL done_out: got sign=%0b blank=%05b bcd=%05h expected sign=%0b blank=%05b bcd=%05h at %0t",
                   sign, blank, bcd, mon_exp[25], mon_exp[24:20], mon_exp[19:0], $time);
        end
      end
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_with_done: got busy=%0b expected 0 at %0t", busy, $time);
      end
    end
  end

  task automatic wait_done(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one at %0t", lat, $time);
    end
  endtask

  task automatic issue(input logic [15:0] r, input logic [EXP_W-1:0] e);
    @(negedge clk);
    start  = 1'b1;
    result = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    result = 16'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  int          lat;
  int          d0;
  logic [15:0] rv;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_sign",  32'(sign),  32'd0);
    check("rst_bcd",   32'(bcd),   32'd0);
    check("rst_blank", 32'(blank), 32'b11110);

    for (int i = 0; i < 9; i++) begin
      issue(dir_tab[i].r, {dir_tab[i].s, dir_tab[i].blk, dir_tab[i].b});
      wait_done(lat);
      check("latency", 32'(lat), 32'd16);
    end

    // outputs hold between conversions
    repeat (5) @(negedge clk);
    check("hold_bcd",  32'(bcd),   32'h00099);
    check("hold_sign", 32'(sign),  32'd1);
    check("hold_blank", 32'(blank), 32'b11100);

    // start held through busy; taken again in the DONE cycle
    d0 = done_cnt;
    @(negedge clk);
    start  = 1'b1;
    result = 16'h0009;
    exp_q.push_back({1'b0, 5'b11110, 20'h00009});
    @(posedge clk);
    #1;
    result = 16'h0063;
    exp_q.push_back({1'b0, 5'b11100, 20'h00099});
    wait_done(lat);
    check("b2b_latency1", 32'(lat), 32'd16);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_latency2", 32'(lat), 32'd16);
    repeat (20) @(negedge clk);
    check("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);

    // reset in the middle of a conversion
    @(negedge clk);
    start  = 1'b1;
    result = 16'h3039;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_bcd",   32'(bcd),   32'd0);
    check("abort_sign",  32'(sign),  32'd0);
    check("abort_blank", 32'(blank), 32'b11110);
    d0 = done_cnt;
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    issue(16'h3039, {1'b0, 5'b00000, 20'h12345});
    wait_done(lat);
    check("latency_after_abort", 32'(lat), 32'd16);

    for (int i = 0; i < 2000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      issue(rv, model(rv));
      wait_done(lat);
      check("sweep_latency", 32'(lat), 32'd16);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
